// File: rtl/pace_to_speed.sv
// Target pace (MMSS BCD) to speed in knots x10.
// Multicycle restoring divide: DIST_CONST / pace_seconds.
module pace_to_speed #(
  parameter int unsigned DIST_CONST = 36000,
  parameter int          W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   d0_pace,
  input  logic [3:0]   d1_pace,
  input  logic [3:0]   d2_pace,
  input  logic [3:0]   d3_pace,
  output logic         busy,
  output logic [W-1:0] pace_seconds,
  output logic [W-1:0] speed_scaled,
  output logic         speed_valid,
  output logic         sat,
  output logic         err
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DIVIDE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    d0_q, d0_d;
  logic [3:0]    d1_q, d1_d;
  logic [3:0]    d2_q, d2_d;
  logic [3:0]    d3_q, d3_d;
  logic [W-1:0]  pace_q, pace_d;
  logic [W-1:0]  speed_q, speed_d;
  logic          sat_q, sat_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          bad;
  logic [W-1:0]  secs;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;
  logic          ge;
  logic [W-1:0]  quo_nxt;

  assign bad = (d0_q > 4'd9) | (d1_q > 4'd9)
             | (d2_q > 4'd5) | (d3_q > 4'd9);

  assign secs = (W'(d0_q) * W'(10) + W'(d1_q)) * W'(60)
              + W'(d2_q) * W'(10) + W'(d3_q);

  // Remainder stays below the divisor, so its top bit is free to shift into.
  assign rem_sh  = {rem_q[W-1:0], dvd_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign quo_nxt = {dvd_q[W-2:0], ge};

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    pace_d  = pace_q;
    speed_d = speed_q;
    sat_d   = sat_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          d0_d    = d0_pace;
          d1_d    = d1_pace;
          d2_d    = d2_pace;
          d3_d    = d3_pace;
          sat_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (bad) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          pace_d = secs;
          if (secs == '0) begin
            speed_d = '1;
            sat_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = W'(DIST_CONST);
            dvs_d   = secs;
            cnt_d   = CW'(W - 1);
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = ge ? rem_sub : rem_sh;
        dvd_d = quo_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          speed_d = quo_nxt;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      pace_q  <= '0;
      speed_q <= '0;
      sat_q   <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      pace_q  <= pace_d;
      speed_q <= speed_d;
      sat_q   <= sat_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = state_q != IDLE;
  assign speed_valid  = state_q == DONE;
  assign pace_seconds = pace_q;
  assign speed_scaled = speed_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_pace_to_speed.sv
// Directed bench for pace_to_speed.
// Hand-computed speeds, latencies and handshake pulse counts.
module tb_pace_to_speed;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  d0, d1, d2, d3;
  logic        busy;
  logic [15:0] pace_seconds;
  logic [15:0] speed_scaled;
  logic        speed_valid;
  logic        sat;
  logic        err;

  int total;
  int bad;

  int v_lat, v_cnt, e_lat, e_cnt, b_cnt;
  logic [15:0] v_spd;
  logic        v_sat;

  pace_to_speed dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .d0_pace     (d0),
    .d1_pace     (d1),
    .d2_pace     (d2),
    .d3_pace     (d3),
    .busy        (busy),
    .pace_seconds(pace_seconds),
    .speed_scaled(speed_scaled),
    .speed_valid (speed_valid),
    .sat         (sat),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a start, then watch a fixed 30-cycle window.
  // inj>0: raise start with 00:01 digits at that cycle of the window.
  task automatic run(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] d,
                     input int inj);
    d0 = a; d1 = b; d2 = c; d3 = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    v_lat = -1; v_cnt = 0; e_lat = -1; e_cnt = 0; b_cnt = 0;
    v_spd = '0; v_sat = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (busy) b_cnt++;
      if (speed_valid) begin
        v_cnt++;
        if (v_lat < 0) begin
          v_lat = i;
          v_spd = speed_scaled;
          v_sat = sat;
        end
      end
      if (err) begin
        e_cnt++;
        if (e_lat < 0) e_lat = i;
      end
      if (i == inj) begin
        d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", speed_valid, 0);
    chk("rst_speed", speed_scaled, 0);
    chk("rst_pace", pace_seconds, 0);
    chk("rst_sat", sat, 0);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run(4'd0, 4'd7, 4'd3, 4'd0, 0);
    chk("nom_speed", v_spd, 80);
    chk("nom_pace", pace_seconds, 450);
    chk("nom_lat", v_lat, 18);
    chk("nom_pulses", v_cnt, 1);
    chk("nom_busy", b_cnt, 18);
    chk("nom_err", e_cnt, 0);

    run(4'd0, 4'd0, 4'd0, 4'd1, 0);
    chk("p0001_speed", v_spd, 36000);
    run(4'd9, 4'd9, 4'd5, 4'd9, 0);
    chk("p9959_speed", v_spd, 6);
    chk("p9959_pace", pace_seconds, 5999);
    run(4'd0, 4'd1, 4'd0, 4'd0, 0);
    chk("p0100_speed", v_spd, 600);
    run(4'd0, 4'd0, 4'd0, 4'd7, 0);
    chk("p0007_speed", v_spd, 5142);

    run(4'd0, 4'd0, 4'd0, 4'd0, 0);
    chk("zero_speed", v_spd, 16'hFFFF);
    chk("zero_sat", v_sat, 1);
    chk("zero_lat", v_lat, 2);
    chk("zero_pace", pace_seconds, 0);
    chk("zero_busy", b_cnt, 2);
    run(4'd0, 4'd6, 4'd0, 4'd0, 0);
    chk("after0_speed", v_spd, 100);
    chk("after0_sat", v_sat, 0);

    run(4'd0, 4'd5, 4'd6, 4'd0, 0);
    chk("bad_d2_err_lat", e_lat, 1);
    chk("bad_d2_err_cnt", e_cnt, 1);
    chk("bad_d2_valid", v_cnt, 0);
    chk("bad_d2_speed", speed_scaled, 100);
    chk("bad_d2_pace", pace_seconds, 360);
    run(4'd0, 4'd1, 4'd0, 4'hA, 0);
    chk("bad_d3_err_lat", e_lat, 1);
    chk("bad_d3_err_cnt", e_cnt, 1);
    chk("bad_d3_valid", v_cnt, 0);
    chk("bad_d3_speed", speed_scaled, 100);

    run(4'd0, 4'd7, 4'd3, 4'd0, 6);
    chk("busy_speed", v_spd, 80);
    chk("busy_pulses", v_cnt, 1);
    chk("busy_lat", v_lat, 18);
    chk("busy_final", speed_scaled, 80);

    d0 = 4'd0; d1 = 4'd7; d2 = 4'd3; d3 = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_speed", speed_scaled, 0);
    chk("mrst_pace", pace_seconds, 0);
    chk("mrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    v_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (speed_valid) v_cnt++;
      tick();
    end
    chk("mrst_novalid", v_cnt, 0);

    run(4'd1, 4'd2, 4'd0, 4'd0, 0);
    chk("p1200_speed", v_spd, 50);
    chk("p1200_pace", pace_seconds, 720);
    chk("p1200_lat", v_lat, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pace_to_speed.md
Name: pace_to_speed

Overview:
- Inverse of the speed-to-pace path: takes a target pace entered as MMSS BCD digits from the UI and produces speed in knots×10 (speed_scaled format).
- Feeds the target-speed comparator and LED pace-alarm logic.
- Uses a multicycle restoring divider, so no combinational 16-bit divide is synthesized.
- Single request/response handshake: start pulse in, busy while working, one-cycle speed_valid (or err) pulse out.

Parameters:
- DIST_CONST, 36000, dividend in seconds·(knots×10) per mile; speed_scaled = floor(DIST_CONST / pace_seconds).
- W, 16, width of dividend, divisor, quotient and pace_seconds.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- d0_pace  input  4  BCD tens of minutes.
- d1_pace  input  4  BCD ones of minutes.
- d2_pace  input  4  BCD tens of seconds.
- d3_pace  input  4  BCD ones of seconds.
- busy  output  1  high from the cycle after an accepted start through the speed_valid/err cycle, inclusive.
- pace_seconds  output W  captured total seconds per mile.
- speed_scaled  output W  knots×10 result.
- speed_valid  output 1  one-cycle pulse; speed_scaled valid from that cycle until the next result.
- sat  output  1  set with speed_valid when pace_seconds==0; cleared on the next accepted start.
- err  output  1  one-cycle pulse on invalid digits.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - The divider registers are cleared.
  - Reset mid-operation aborts with no pulse.
- The FSM has four states: IDLE, CONVERT, DIVIDE, DONE.
- IDLE:
  - On start=1, the four digits are captured into internal registers; later digit changes are ignored.
  - sat is cleared. Next state is CONVERT.
  - start while not in IDLE is ignored and not queued.
- CONVERT (1 cycle):
  - Digit check: any digit >9, or d2>5, means err=1 for one cycle and a return to IDLE. speed_scaled, pace_seconds and speed_valid are unchanged.
  - Otherwise pace_seconds = (d0·10+d1)·60 + d2·10+d3. Range is 0..5999.
  - If pace_seconds==0, skip DIVIDE: speed_scaled=16'hFFFF, sat=1, go to DONE.
  - Otherwise load the remainder with 0, the dividend with DIST_CONST, the divisor with pace_seconds and the iteration counter with W-1. Go to DIVIDE.
- DIVIDE (exactly W cycles, one quotient bit per cycle, MSB first):
  - Shift {rem, dividend} left 1 bit.
  - If rem ≥ divisor: rem -= divisor, quotient bit = 1.
  - Leave after the counter reaches 0.
  - The remainder needs W+1 bits to avoid overflow.
- DONE (1 cycle):
  - speed_scaled = quotient, floor (truncation, same rounding as the forward path).
  - speed_valid=1 for one cycle; next state IDLE. busy is high in DONE and low in the following IDLE.
- Latency:
  - Start sampled at edge k. speed_valid is high in the cycle after edge k+W+2, i.e. 18 cycles after start for W=16.
  - The saturated path is faster: valid after edge k+2.
  - The err path: err high after edge k+1.
- Back-to-back: a start held high in the IDLE cycle right after DONE is accepted, giving one request per W+3 cycles.
- Quotient never exceeds DIST_CONST (36000 < 2^16), so no overflow for W=16.

Test Plan:
- Nominal: reset release, start with 0,7,3,0 (07:30) → pace_seconds=450, speed_scaled=80, speed_valid exactly one cycle, 18 cycles after start; busy high 18 cycles.
- Range ends:
  - 00:01 → speed_scaled=36000.
  - 99:59 → pace_seconds=5999, speed_scaled=6.
  - 01:00 → speed_scaled=600.
  - 00:07 → speed_scaled=5142 (truncation check).
- Zero pace: 00:00 → speed_scaled=16'hFFFF, sat=1, speed_valid 2 cycles after start. A following start of 06:00 → sat=0, speed_scaled=100.
- Invalid digits:
  - 0,5,6,0 → err one cycle after start, no speed_valid, prior speed_scaled retained.
  - d3=4'hA → same.
- Busy protection: start 07:30, then a second start with 00:01 and digits changed to 00:01 mid-divide → single result of 80, no second pulse.
- Reset mid-divide: rst_n=0 asserted 8 cycles after start → outputs immediately 0, no speed_valid after release. A new start of 12:00 (720) → speed_scaled=50.
